// File: rtl/conv_channel_accumulator.sv
// Sums `channel` adder-tree partials into one conv pixel, then applies bias, ReLU, shift and
// saturation, and queues the pixel in a first-word-fall-through FIFO with a valid/ready port.
module conv_channel_accumulator #(
  parameter int pic_bits         = 2,
  parameter int weight_bits      = 3,
  parameter int kernel_size      = 5,
  parameter int kernel_number    = 1,
  parameter int channel          = 1,
  parameter int conv_result_bits = $clog2(kernel_size*kernel_size*kernel_number*channel)
                                   + weight_bits + 1,
  parameter int TREE_LATENCY     = 5,
  parameter int BIAS_BITS        = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int ACC_BITS         = conv_result_bits + $clog2(channel) + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tag_valid,
  input  logic [conv_result_bits-1:0] tree_result,
  input  logic [BIAS_BITS-1:0]        bias,
  input  logic [2:0]                  shift,
  output logic [pic_bits-1:0]         out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  output logic                        busy
);

  localparam int CNT_BITS  = (channel > 1) ? $clog2(channel) : 1;
  localparam int PTR_BITS  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int POST_BITS = ((ACC_BITS > BIAS_BITS) ? ACC_BITS : BIAS_BITS) + 1;
  localparam int PIX_MAX   = (1 << pic_bits) - 1;

  logic [TREE_LATENCY-1:0]     tag_sr_q;
  logic                        d_valid;
  logic                        last_ch;
  logic [CNT_BITS-1:0]         ch_cnt_q, ch_cnt_d;
  logic signed [ACC_BITS-1:0]  acc_q, acc_d, tree_ext;
  logic signed [POST_BITS-1:0] post_in_q, post_in_d, shifted;
  logic                        post_vld_q;
  logic [pic_bits-1:0]         pix;

  logic [pic_bits-1:0]         mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]           count_q, count_d;
  logic                        fifo_empty, fifo_full, push, pop, overflow_q;

  // The tree has no valid of its own; this delay line (TREE_LATENCY >= 2) marks its outputs.
  assign d_valid  = tag_sr_q[TREE_LATENCY-1];
  assign tree_ext = {{(ACC_BITS-conv_result_bits){tree_result[conv_result_bits-1]}}, tree_result};
  assign last_ch  = (ch_cnt_q == CNT_BITS'(channel - 1));

  always_comb begin
    acc_d     = (ch_cnt_q == '0) ? tree_ext : acc_q + tree_ext;
    ch_cnt_d  = last_ch ? '0 : ch_cnt_q + CNT_BITS'(1);
    post_in_d = {{(POST_BITS-ACC_BITS){acc_d[ACC_BITS-1]}}, acc_d}
              + {{(POST_BITS-BIAS_BITS){bias[BIAS_BITS-1]}}, bias};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_sr_q   <= '0;
      ch_cnt_q   <= '0;
      acc_q      <= '0;
      post_in_q  <= '0;
      post_vld_q <= 1'b0;
    end else begin
      tag_sr_q   <= {tag_sr_q[TREE_LATENCY-2:0], tag_valid};
      post_vld_q <= 1'b0;
      if (d_valid) begin
        acc_q    <= acc_d;
        ch_cnt_q <= ch_cnt_d;
        if (last_ch) begin
          post_in_q  <= post_in_d;
          post_vld_q <= 1'b1;
        end
      end
    end
  end

  // ReLU, rescale, then clamp to the unsigned pixel range.
  always_comb begin
    shifted = post_in_q >>> shift;
    if (post_in_q[POST_BITS-1]) begin
      pix = '0;
    end else if ($unsigned(shifted) > POST_BITS'(PIX_MAX)) begin
      pix = pic_bits'(PIX_MAX);
    end else begin
      pix = shifted[pic_bits-1:0];
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_BITS+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && out_ready;
  assign push       = post_vld_q && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
      2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      end
      if (post_vld_q && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Gate the head so an empty FIFO never exposes a stale entry.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign busy      = (ch_cnt_q != '0) || (|tag_sr_q) || post_vld_q;

endmodule
